// File: rtl/vdic_dut_2023_pkg.sv
// vdic_dut_2023_pkg
// Shared widths, FSM state type and helper functions for the
// parity-protected multiply responder and its sequential engine.
package vdic_dut_2023_pkg;

  localparam int unsigned ARG_W  = 16;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned ITER_N = 16;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Even parity over a full result-width word; narrower values are zero-extended.
  function automatic logic calc_parity(input logic [RES_W-1:0] v);
    return ^v;
  endfunction

  // Unsigned magnitude of a signed operand; -32768 maps to 32768 (0x8000).
  function automatic logic [ARG_W-1:0] calc_mag(input logic [ARG_W-1:0] v);
    return v[ARG_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/vdic_mult_seq_core.sv
// vdic_mult_seq_core
// Radix-2 shift-add multiplier: one iteration per clock, ITER_N iterations.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        load operands and begin (clears done)
//   mag_a, mag_b unsigned operand magnitudes
//   sign         negate the final product when set
//   done         high from the edge completing the last iteration until next start
//   product      signed product (valid while done)
module vdic_mult_seq_core
  import vdic_dut_2023_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ARG_W-1:0] mag_a,
  input  logic [ARG_W-1:0] mag_b,
  input  logic             sign,
  output logic             done,
  output logic [RES_W-1:0] product
);

  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [ARG_W-1:0] mplier_q, mplier_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state of the shift-add datapath.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (start) begin
      mcand_d  = {16'd0, mag_a};
      mplier_d = mag_b;
      acc_d    = 32'd0;
      cnt_d    = 5'd0;
      sign_d   = sign;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[RES_W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[ARG_W-1:1]};
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == CNT_W'(ITER_N - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= 32'd0;
      mplier_q <= 16'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = sign_q ? (32'd0 - acc_q) : acc_q;

endmodule

// File: rtl/vdic_mult_responder.sv
// vdic_mult_responder
// Responder side of the parity-protected multiply handshake.
// Build option: define VDIC_MULT_SEQ_EN for the 16-iteration shift-add engine;
// otherwise a single-cycle combinational multiply is used.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   arg_a, arg_b        signed 16-bit operands, with even parity bits
//   req / ack           request (operands valid) / operands captured
//   result, result_parity  signed 32-bit product (0 on parity error) and ^result
//   result_rdy          one-cycle strobe, result fields valid
//   arg_parity_error    either operand parity was wrong
module vdic_mult_responder
  import vdic_dut_2023_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ARG_W-1:0] arg_a,
  input  logic             arg_a_parity,
  input  logic [ARG_W-1:0] arg_b,
  input  logic             arg_b_parity,
  input  logic             req,
  output logic             ack,
  output logic [RES_W-1:0] result,
  output logic             result_parity,
  output logic             result_rdy,
  output logic             arg_parity_error
);

  state_t           state_q, state_d;
  logic [ARG_W-1:0] a_q, a_d, b_q, b_d;
  logic             a_par_q, a_par_d, b_par_q, b_par_d;
  logic             ack_q, ack_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             result_parity_q, result_parity_d;
  logic             result_rdy_q, result_rdy_d;
  logic             err_q, err_d;

  logic             err_s;
  logic             eng_done_s;
  logic [RES_W-1:0] product_s;

  assign err_s = (calc_parity({16'd0, a_q}) != a_par_q) |
                 (calc_parity({16'd0, b_q}) != b_par_q);

`ifdef VDIC_MULT_SEQ_EN
  logic start_s;

  // The engine loads straight from the ports on the capture edge so that
  // its sixteen iterations land on E1..E16.
  assign start_s = (state_q == IDLE) && req;

  vdic_mult_seq_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .mag_a   (calc_mag(arg_a)),
    .mag_b   (calc_mag(arg_b)),
    .sign    (arg_a[ARG_W-1] ^ arg_b[ARG_W-1]),
    .done    (eng_done_s),
    .product (product_s)
  );
`else
  logic [RES_W-1:0] umul_s;

  assign umul_s     = 32'(calc_mag(a_q)) * 32'(calc_mag(b_q));
  assign product_s  = (a_q[ARG_W-1] ^ b_q[ARG_W-1]) ? (32'd0 - umul_s) : umul_s;
  assign eng_done_s = 1'b1;
`endif

  // Handshake FSM next-state and output computation.
  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    a_par_d         = a_par_q;
    b_par_d         = b_par_q;
    ack_d           = ack_q;
    result_d        = result_q;
    result_parity_d = result_parity_q;
    result_rdy_d    = 1'b0;
    err_d           = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          a_d     = arg_a;
          b_d     = arg_b;
          a_par_d = arg_a_parity;
          b_par_d = arg_b_parity;
          ack_d   = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!req) begin
          ack_d = 1'b0;
        end else begin
          ack_d = ack_q;
        end
        // A parity error short-circuits the engine.
        if (!req && (err_s || eng_done_s)) begin
          result_d        = err_s ? 32'd0 : product_s;
          result_parity_d = err_s ? 1'b0 : calc_parity(product_s);
          err_d           = err_s;
          result_rdy_d    = 1'b1;
          state_d         = OUT;
        end else begin
          state_d = BUSY;
        end
      end
      OUT: begin
        result_rdy_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      a_q             <= 16'd0;
      b_q             <= 16'd0;
      a_par_q         <= 1'b0;
      b_par_q         <= 1'b0;
      ack_q           <= 1'b0;
      result_q        <= 32'd0;
      result_parity_q <= 1'b0;
      result_rdy_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      a_par_q         <= a_par_d;
      b_par_q         <= b_par_d;
      ack_q           <= ack_d;
      result_q        <= result_d;
      result_parity_q <= result_parity_d;
      result_rdy_q    <= result_rdy_d;
      err_q           <= err_d;
    end
  end

  assign ack              = ack_q;
  assign result           = result_q;
  assign result_parity    = result_parity_q;
  assign result_rdy       = result_rdy_q;
  assign arg_parity_error = err_q;

endmodule

// File: tb/tb_vdic_mult_responder.sv
module tb_vdic_mult_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;
  logic        req;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  int tests;
  int fails;

`ifdef VDIC_MULT_SEQ_EN
  localparam int BASE_LAT = 17;
`else
  localparam int BASE_LAT = 1;
`endif

  vdic_mult_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the most recent transaction.
  int          obs_lat;
  int          obs_pulses;
  int          obs_ack_cycles;
  logic        obs_overlap;
  logic [31:0] obs_result;
  logic        obs_rpar;
  logic        obs_err;

  // BFM: drive one request; req falls 'hold' negedges after the one following E0.
  // Watches 24 cycles after E0 and records what the DUT did.
  task automatic drive_txn(input logic [15:0] a, input logic ap,
                           input logic [15:0] b, input logic bp, input int hold);
    @(negedge clk);
    arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
    @(posedge clk);  // E0
    obs_lat = -1; obs_pulses = 0; obs_ack_cycles = 0; obs_overlap = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);  // after edge E(k-1)
      if (ack) obs_ack_cycles++;
      if (result_rdy) begin
        obs_pulses++;
        if (obs_lat < 0) obs_lat = k - 1;
      end
      if (ack && result_rdy) obs_overlap = 1'b1;
      if (k > hold) req = 1'b0;
    end
    obs_result = result; obs_rpar = result_parity; obs_err = arg_parity_error;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1;
    arg_a = 16'h0003; arg_a_parity = 1'b0; arg_b = 16'h0005; arg_b_parity = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ack !== 1'b0 || result_rdy !== 1'b0 || result !== 32'd0 ||
        result_parity !== 1'b0 || arg_parity_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b rdy=%b result=%h rpar=%b err=%b, required all 0",
               ack, result_rdy, result, result_parity, arg_parity_error);
    end
    req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_capture: ack=%b, required 0", ack);
    end
  endtask

  task automatic test_basic();
    drive_txn(16'h0003, 1'b0, 16'hFFFB, 1'b1, 0);
    tests++;
    if (obs_result !== 32'hFFFF_FFF1 || obs_rpar !== 1'b1 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_3x-5: result=%h rpar=%b err=%b, required FFFFFFF1 1 0",
               obs_result, obs_rpar, obs_err);
    end
    tests++;
    if (obs_pulses != 1 || obs_lat != BASE_LAT) begin
      fails++;
      $display("FAIL basic_rdy: pulses=%0d lat=%0d, required 1 %0d",
               obs_pulses, obs_lat, BASE_LAT);
    end
    tests++;
    if (obs_ack_cycles != 1 || obs_overlap !== 1'b0) begin
      fails++;
      $display("FAIL basic_ack: ack_cycles=%0d overlap=%b, required 1 0",
               obs_ack_cycles, obs_overlap);
    end
  endtask

  task automatic test_min_neg();
    drive_txn(16'h8000, 1'b1, 16'h8000, 1'b1, 0);
    tests++;
    if (obs_result !== 32'h4000_0000 || obs_rpar !== 1'b1 || obs_err !== 1'b0 ||
        obs_pulses != 1) begin
      fails++;
      $display("FAIL min_neg_sq: result=%h rpar=%b err=%b pulses=%0d, required 40000000 1 0 1",
               obs_result, obs_rpar, obs_err, obs_pulses);
    end
    // -1 * -1 = 1
    drive_txn(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 0);
    tests++;
    if (obs_result !== 32'h0000_0001 || obs_rpar !== 1'b1 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL neg1_sq: result=%h rpar=%b err=%b, required 00000001 1 0",
               obs_result, obs_rpar, obs_err);
    end
    // 0 * -1 = 0
    drive_txn(16'h0000, 1'b0, 16'hFFFF, 1'b0, 0);
    tests++;
    if (obs_result !== 32'h0000_0000 || obs_rpar !== 1'b0 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL zero_x_neg1: result=%h rpar=%b err=%b, required 00000000 0 0",
               obs_result, obs_rpar, obs_err);
    end
  endtask

  task automatic test_parity_error();
    drive_txn(16'h7FFF, 1'b0, 16'h0002, 1'b1, 0);
    tests++;
    if (obs_result !== 32'd0 || obs_rpar !== 1'b0 || obs_err !== 1'b1) begin
      fails++;
      $display("FAIL parity_err_a: result=%h rpar=%b err=%b, required 00000000 0 1",
               obs_result, obs_rpar, obs_err);
    end
    tests++;
    if (obs_lat != 1 || obs_pulses != 1) begin
      fails++;
      $display("FAIL parity_err_lat: lat=%0d pulses=%0d, required 1 1", obs_lat, obs_pulses);
    end
    // Bad b parity; a valid. 5*5 would be 25 but must be suppressed.
    drive_txn(16'h0005, 1'b0, 16'h0005, 1'b1, 0);
    tests++;
    if (obs_result !== 32'd0 || obs_err !== 1'b1 || obs_lat != 1) begin
      fails++;
      $display("FAIL parity_err_b: result=%h err=%b lat=%0d, required 00000000 1 1",
               obs_result, obs_err, obs_lat);
    end
  endtask

  task automatic test_req_hold();
    int exp_lat;
    exp_lat = (BASE_LAT > 6) ? BASE_LAT : 6;
    drive_txn(16'h0007, 1'b1, 16'h0006, 1'b0, 5);
    tests++;
    if (obs_ack_cycles != 6 || obs_overlap !== 1'b0) begin
      fails++;
      $display("FAIL hold_ack: ack_cycles=%0d overlap=%b, required 6 0",
               obs_ack_cycles, obs_overlap);
    end
    tests++;
    if (obs_pulses != 1 || obs_lat != exp_lat) begin
      fails++;
      $display("FAIL hold_rdy: pulses=%0d lat=%0d, required 1 %0d",
               obs_pulses, obs_lat, exp_lat);
    end
    tests++;
    if (obs_result !== 32'h0000_002A || obs_rpar !== 1'b1 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL hold_result: result=%h rpar=%b err=%b, required 0000002A 1 0",
               obs_result, obs_rpar, obs_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    int acks;
    pulses = 0; acks = 0;
    @(negedge clk);
    arg_a = 16'h1234; arg_a_parity = 1'b1; arg_b = 16'h0003; arg_b_parity = 1'b0; req = 1'b1;
    @(posedge clk);  // E0, FSM enters BUSY; req still high so no result yet
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (result_rdy) pulses++;
      if (ack) acks++;
    end
    tests++;
    if (pulses != 0 || acks != 0 || result !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_busy: pulses=%0d ack_cycles=%0d result=%h, required 0 0 00000000",
               pulses, acks, result);
    end
    drive_txn(16'h0064, 1'b1, 16'hFF9C, 1'b0, 0);
    tests++;
    if (obs_result !== 32'hFFFF_D8F0 || obs_rpar !== 1'b0 || obs_err !== 1'b0 ||
        obs_pulses != 1) begin
      fails++;
      $display("FAIL after_reset_txn: result=%h rpar=%b err=%b pulses=%0d, required FFFFD8F0 0 0 1",
               obs_result, obs_rpar, obs_err, obs_pulses);
    end
  endtask

  task automatic test_back_to_back();
    // An error transaction followed by a good one: the flag must clear.
    drive_txn(16'h0001, 1'b0, 16'h0001, 1'b1, 0);
    drive_txn(16'h0100, 1'b1, 16'hFFFE, 1'b1, 0);
    tests++;
    if (obs_result !== 32'hFFFF_FE00 || obs_rpar !== 1'b1 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_256x-2: result=%h rpar=%b err=%b, required FFFFFE00 1 0",
               obs_result, obs_rpar, obs_err);
    end
    drive_txn(16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 0);
    tests++;
    if (obs_result !== 32'h3FFF_0001 || obs_rpar !== 1'b1 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_max_sq: result=%h rpar=%b err=%b, required 3FFF0001 1 0",
               obs_result, obs_rpar, obs_err);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; req = 1'b0;
    arg_a = 16'd0; arg_a_parity = 1'b0; arg_b = 16'd0; arg_b_parity = 1'b0;
    test_reset();
    test_basic();
    test_min_neg();
    test_parity_error();
    test_req_hold();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
